// File: rtl/interrupt_request_register.sv
// Interrupt request register for an 8259A-compatible PIC: latches IR lines in
// edge or level mode, forwards unmasked requests and exposes raw contents.
module interrupt_request_register (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR0_to_IR7,
    input  logic [7:0] bitToMask,
    input  logic       readPriority,
    input  logic       readIRR,
    input  logic [2:0] resetIRR,
    input  logic [7:0] ICW1,
    output logic [7:0] risedBits,
    output logic [7:0] dataBuffer
);

    localparam int unsigned N_IR = 8;
    localparam int unsigned LTIM_BIT = 3;

    logic [N_IR-1:0] r_irr;
    logic [N_IR-1:0] r_ir_prev;
    logic [N_IR-1:0] w_clear;
    logic [N_IR-1:0] w_rise;
    logic [N_IR-1:0] w_irr_next;
    logic            w_level_mode;
    logic            w_unused_icw1;

    assign w_level_mode  = ICW1[LTIM_BIT];
    assign w_unused_icw1 = ^{ICW1[7:4], ICW1[2:0]};

    // One-hot clear of the acknowledged request; index ignored without the strobe.
    always_comb begin
        w_clear = '0;
        if (readPriority) begin
            w_clear[resetIRR] = 1'b1;
        end
    end

    // Clear has priority over both level tracking and edge set.
    always_comb begin
        w_rise     = IR0_to_IR7 & ~r_ir_prev;
        w_irr_next = w_level_mode ? IR0_to_IR7 : (r_irr | w_rise);
        w_irr_next = w_irr_next & ~w_clear;
    end

    // Prev is preset high so lines already asserted at reset need a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irr     <= '0;
            r_ir_prev <= '1;
        end else begin
            r_irr     <= w_irr_next;
            r_ir_prev <= IR0_to_IR7;
        end
    end

    assign risedBits  = r_irr & ~bitToMask;
    assign dataBuffer = readIRR ? r_irr : N_IR'(0);

endmodule

// File: tb/tb_interrupt_request_register.sv
// Self-checking bench for interrupt_request_register: directed vector table,
// hand-written corner sequences and a randomized run against a per-bit model.
module tb_interrupt_request_register;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IR0_to_IR7;
    logic [7:0] bitToMask;
    logic       readPriority;
    logic       readIRR;
    logic [2:0] resetIRR;
    logic [7:0] ICW1;
    logic [7:0] risedBits;
    logic [7:0] dataBuffer;

    interrupt_request_register dut (
        .clk          (clk),
        .reset        (reset),
        .IR0_to_IR7   (IR0_to_IR7),
        .bitToMask    (bitToMask),
        .readPriority (readPriority),
        .readIRR      (readIRR),
        .resetIRR     (resetIRR),
        .ICW1         (ICW1),
        .risedBits    (risedBits),
        .dataBuffer   (dataBuffer)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] ir;
        logic [7:0] mask;
        logic       rp;
        logic [2:0] idx;
        logic       rd;
        logic [7:0] icw;
        logic [7:0] exp_rb;
        logic [7:0] exp_db;
        string      tag;
    } vec_t;

    typedef struct {
        logic [7:0] rb;
        logic [7:0] db;
        string      tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state for the randomized section
    logic [7:0] m_irr;
    logic [7:0] m_prev;

    task automatic add(input logic rst, input logic [7:0] ir, input logic [7:0] mask,
                       input logic rp, input logic [2:0] idx, input logic rd,
                       input logic [7:0] icw, input logic [7:0] exp_rb,
                       input logic [7:0] exp_db, input string tag);
        vec_t v;
        v.rst = rst; v.ir = ir; v.mask = mask; v.rp = rp; v.idx = idx; v.rd = rd;
        v.icw = icw; v.exp_rb = exp_rb; v.exp_db = exp_db; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, push its expectation, clock, then pop and compare.
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        reset        = v.rst;
        IR0_to_IR7   = v.ir;
        bitToMask    = v.mask;
        readPriority = v.rp;
        resetIRR     = v.idx;
        readIRR      = v.rd;
        ICW1         = v.icw;
        e.rb = v.exp_rb; e.db = v.exp_db; e.tag = v.tag;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty got 0 entries required 1", v.tag);
        end else begin
            got = sb.pop_front();
            check8({got.tag, ".risedBits"}, risedBits, got.rb);
            check8({got.tag, ".dataBuffer"}, dataBuffer, got.db);
        end
    endtask

    task automatic model_step(input vec_t v);
        if (v.rst) begin
            m_irr  = 8'h00;
            m_prev = 8'hFF;
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (v.rp && (int'(v.idx) == n))
                    m_irr[n] = 1'b0;
                else if (v.icw[3])
                    m_irr[n] = v.ir[n];
                else if (v.ir[n] && !m_prev[n])
                    m_irr[n] = 1'b1;
            end
            m_prev = v.ir;
        end
    endtask

    initial begin
        vec_t v;
        logic [7:0] m;

        reset = 1'b1; IR0_to_IR7 = 8'h00; bitToMask = 8'h00; readPriority = 1'b0;
        readIRR = 1'b0; resetIRR = 3'd0; ICW1 = 8'h00;

        //   rst ir     mask   rp idx rd icw    rb     db     tag
        add(1, 8'hFF, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, "reset_ffheld");
        add(0, 8'hFF, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, "edge_held_high0");
        add(0, 8'hFF, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, "edge_held_high1");
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, "edge_drop");
        add(0, 8'h01, 8'h00, 0, 0, 1, 8'h00, 8'h01, 8'h01, "edge_rise_ir0");
        add(0, 8'h01, 8'h00, 0, 0, 1, 8'h00, 8'h01, 8'h01, "edge_hold_ir0");
        add(0, 8'h6A, 8'hB4, 0, 0, 1, 8'h08, 8'h4A, 8'h6A, "level_mask_rd1");
        add(0, 8'h6A, 8'hB4, 0, 0, 0, 8'h08, 8'h4A, 8'h00, "level_mask_rd0");
        add(1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, "reset2");
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, "edge_idle");
        add(0, 8'h40, 8'h00, 0, 0, 1, 8'h00, 8'h40, 8'h40, "edge_ir6_rise");
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h40, 8'h40, "edge_ir6_sticky");
        add(0, 8'h00, 8'h00, 0, 6, 1, 8'h00, 8'h40, 8'h40, "no_strobe_idx6");
        add(0, 8'h00, 8'h00, 1, 6, 1, 8'h00, 8'h00, 8'h00, "clear_ir6");
        add(0, 8'h00, 8'h00, 0, 6, 1, 8'h00, 8'h00, 8'h00, "after_clear_ir6");
        add(0, 8'h40, 8'h00, 0, 0, 1, 8'h08, 8'h40, 8'h40, "level_ir6_high");
        add(0, 8'h40, 8'h00, 1, 6, 1, 8'h08, 8'h00, 8'h00, "level_clear_ir6");
        add(0, 8'h40, 8'h00, 0, 6, 1, 8'h08, 8'h40, 8'h40, "level_reset_ir6");
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'h08, 8'h00, 8'h00, "level_withdraw");
        add(0, 8'hFF, 8'h00, 0, 0, 1, 8'h08, 8'hFF, 8'hFF, "sweep_fill");
        for (int k = 0; k < 8; k++) begin
            m = 8'h01 << k;
            add(0, 8'hFF, m, 0, 0, 1, 8'h08, ~m, 8'hFF, $sformatf("mask_sweep%0d", k));
        end
        add(1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, "reset3");
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, "edge_idle2");
        add(0, 8'h28, 8'h00, 1, 3, 1, 8'h00, 8'h20, 8'h20, "clear_vs_rise_ir3");
        add(0, 8'h28, 8'h00, 0, 0, 1, 8'h00, 8'h20, 8'h20, "ir3_edge_lost");
        add(0, 8'hA5, 8'h00, 0, 0, 1, 8'h08, 8'hA5, 8'hA5, "level_a5");
        add(1, 8'hA5, 8'h00, 1, 0, 1, 8'h08, 8'h00, 8'h00, "reset_midop");

        @(negedge clk);
        foreach (vecs[i]) apply(vecs[i]);

        // Clear of one bit leaves others; ICW1 non-LTIM bits have no effect.
        v = vecs[0];
        v.rst = 0; v.rd = 1; v.rp = 0; v.mask = 8'h00; v.icw = 8'hF7;
        v.ir = 8'h00; v.exp_rb = 8'h00; v.exp_db = 8'h00; v.tag = "seq_idle"; apply(v);
        v.ir = 8'h81; v.exp_rb = 8'h81; v.exp_db = 8'h81; v.tag = "seq_rise_0_7"; apply(v);
        v.ir = 8'h00; v.rp = 1; v.idx = 3'd0;
        v.exp_rb = 8'h80; v.exp_db = 8'h80; v.tag = "seq_clear_only0"; apply(v);
        // Switching to level mode re-evaluates from the live lines at the next edge.
        v.rp = 0; v.icw = 8'h08; v.ir = 8'h02;
        v.exp_rb = 8'h02; v.exp_db = 8'h02; v.tag = "seq_mode_switch"; apply(v);
        v.mask = 8'h02; v.exp_rb = 8'h00; v.exp_db = 8'h02; v.tag = "seq_masked_latched"; apply(v);

        // Randomized cycles against the per-bit model.
        v.rst = 1; v.ir = 8'h00; v.mask = 8'h00; v.rp = 0; v.idx = 0; v.rd = 1; v.icw = 8'h00;
        model_step(v);
        v.exp_rb = m_irr; v.exp_db = m_irr; v.tag = "rand_reset"; apply(v);
        for (int c = 0; c < 300; c++) begin
            v.rst  = ($urandom_range(0, 40) == 0);
            v.ir   = 8'($urandom);
            v.mask = 8'($urandom);
            v.rp   = 1'($urandom);
            v.idx  = 3'($urandom);
            v.rd   = 1'($urandom);
            v.icw  = ($urandom_range(0, 9) == 0) ? (8'($urandom) ^ 8'h08) : v.icw;
            model_step(v);
            v.exp_rb = m_irr & ~v.mask;
            v.exp_db = v.rd ? m_irr : 8'h00;
            v.tag = $sformatf("rand%0d", c);
            apply(v);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
